truth_table_sequencer: RTL
==========================

Name: truth_table_sequencer

Overview:
Self-checking stimulus controller for a small combinational function block (4-input, 1-output by default). On a start pulse it sweeps every input vector 0..2^N_IN-1, holds each for DWELL cycles, samples the function output, and builds the captured truth table. It compares the table bit-for-bit against an expected mask and reports pass/fail, mismatch count and first failing vector. It sits between the lab's function blocks and the board switches/LEDs, replacing hand-stepped vector benches.

Parameters:
N_IN, 4, number of function inputs; vector count V = 2^N_IN
DWELL, 20, cycles each vector is held before sampling; legal range 1..255

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to begin a sweep; ignored while busy
expected  in  V  expected truth table, bit i = f for vector i; sampled at start
f_in  in  1  output of the function under test
vec_out  out  N_IN  input vector driven to the function under test
busy  out  1  high while sweeping
done  out  1  one-cycle pulse at end of sweep
table_out  out  V  captured truth table
pass  out  1  valid after done: table_out == expected
mismatch_count  out  N_IN+1  number of differing bits, range 0..V
fail_idx  out  N_IN  index of lowest-numbered mismatching vector; 0 if none

Behaviour:
- The clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset values: vec_out=0, busy=0, done=0, table_out=0, pass=0, mismatch_count=0, fail_idx=0, state IDLE, dwell counter 0.
- FSM states:
  - IDLE: on start=1, latch expected, clear table_out, mismatch_count, fail_idx and pass, set vec_out=0, go to APPLY. busy rises on the edge that accepts start.
  - APPLY: the dwell counter counts 0..DWELL-1. On the edge where counter==DWELL-1:
    - write f_in into table_out[vec_out];
    - if f_in != expected_q[vec_out], increment mismatch_count, and set fail_idx=vec_out if this is the first mismatch.
    - If vec_out==V-1, go to DONE; otherwise increment vec_out and reset the counter.
  - DONE: done=1 and pass=(mismatch_count==0) for one cycle; busy drops on entry to DONE; return to IDLE. vec_out holds V-1 until the next start.
- Latency: done is high in the cycle beginning V*DWELL+1 edges after the start-accepting edge. Defaults: 321 cycles.
- start while busy or in DONE is dropped, not queued.
- start held high: re-triggers only from IDLE, giving back-to-back sweeps separated by the single DONE cycle.
- rst mid-sweep: returns everything to reset values on the next edge; no done pulse.
- mismatch_count saturation is impossible by construction, since V fits in N_IN+1 bits.
- Results (table_out, pass, mismatch_count, fail_idx) hold stable in IDLE until the next accepted start.

Optional Feature:
- Macro STOP_ON_FAIL_EN.
- Defined: on the first mismatching sample the FSM goes straight to DONE. In that case mismatch_count=1, fail_idx=the failing vector, table_out bits above fail_idx stay 0, and done is asserted early.
- Undefined: the full sweep always runs, as described in Behaviour.

Decomposition:
- Package tts_pkg holds:
  - the state enum (IDLE, APPLY, DONE);
  - the default N_IN and DWELL constants;
  - a function computing V.
- One natural sub-module, dwell_counter: a parameterised down-counter with load, enable and a terminal-count output. It is reused by other lab blocks.

Test Plan:
1. Bench models f = bit vec of 16'hA5C3; expected=16'hA5C3, start pulse -> after 321 cycles done=1, pass=1, mismatch_count=0, table_out=16'hA5C3.
2. Model 16'hA5C3, expected=16'hA5C2 -> pass=0, mismatch_count=1, fail_idx=0; also expected=16'h5A3C -> mismatch_count=16, fail_idx=0.
3. DWELL=1, model f = a&b&c&d, expected=16'h8000 -> done 17 cycles after start, pass=1; vec_out steps 0..15 on consecutive cycles.
4. Assert rst at cycle 100 of a sweep -> all outputs 0 next edge, no done pulse. Then a new start completes normally.
5. start pulsed at cycles 50 and 200 during a sweep -> ignored; exactly one done.
6. With STOP_ON_FAIL_EN defined, model differs first at vector 9 -> done at cycle 9*DWELL+DWELL+1=201, mismatch_count=1, fail_idx=9, table_out[15:10]=0.

Source files
------------

// File: rtl/tts_pkg.sv
// Shared types and defaults for the truth-table sequencer and its helpers.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } tts_state_e;

  localparam int TTS_N_IN  = 4;
  localparam int TTS_DWELL = 20;

  // Number of input vectors swept for an n_in-input function.
  function automatic int tts_vec_count(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter; tc is high while the count sits at zero.
module dwell_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  // load wins over en; the count parks at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector of a function under test, captures its truth table and
// compares it against an expected mask. Build macro STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module truth_table_sequencer
  import tts_pkg::*;
#(
  parameter  int N_IN  = TTS_N_IN,
  parameter  int DWELL = TTS_DWELL,
  localparam int V     = tts_vec_count(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [V-1:0]    expected,
  input  logic            f_in,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic [V-1:0]    table_out,
  output logic            pass,
  output logic [N_IN:0]   mismatch_count,
  output logic [N_IN-1:0] fail_idx,
  output logic [1:0]      state_dbg
);

  // Handshake: start is a level sampled each clock; it is accepted only when the
  // FSM is IDLE (one sweep per accepting edge) and dropped in APPLY and DONE.

  tts_state_e   state_q, state_d;
  logic [V-1:0] expected_q;
  logic         cnt_load, cnt_en, cnt_tc;
  logic         accept, sample, advance, finish;
  logic         miss, last;

  dwell_counter #(.W(8)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (8'(DWELL - 1)),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    accept   = 1'b0;
    sample   = 1'b0;
    finish   = 1'b0;
    miss     = (f_in != expected_q[vec_out]);
    last     = (vec_out == N_IN'(V - 1));
    case (state_q)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          state_d  = APPLY;
        end
      end
      APPLY: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          sample = 1'b1;
`ifdef STOP_ON_FAIL_EN
          if (last || miss) state_d = DONE;
          else              cnt_load = 1'b1;
`else
          if (last) state_d = DONE;
          else      cnt_load = 1'b1;
`endif
        end
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Step to the next vector only when the sweep continues in APPLY.
  assign advance   = sample && (state_d == APPLY);
  assign busy      = (state_q == APPLY);
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      expected_q     <= '0;
      vec_out        <= '0;
      done           <= 1'b0;
      table_out      <= '0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      fail_idx       <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        expected_q     <= expected;
        vec_out        <= '0;
        table_out      <= '0;
        pass           <= 1'b0;
        mismatch_count <= '0;
        fail_idx       <= '0;
      end
      if (sample) begin
        table_out[vec_out] <= f_in;
        if (miss) begin
          mismatch_count <= mismatch_count + 1'b1;
          if (mismatch_count == '0) fail_idx <= vec_out;
        end
      end
      if (advance) vec_out <= vec_out + 1'b1;
      // done/pass are registered, so they appear one edge after DONE is entered.
      if (finish) begin
        done <= 1'b1;
        pass <= (mismatch_count == '0);
      end
    end
  end

endmodule
